hopsel_kernel: RTL and testbench

HOPSEL_KERNEL -- requirements
Module: hopsel_kernel

---
 rtl/bt_hop_pkg.sv | 46 ++++
 rtl/hop_perm.sv | 35 +++
 rtl/hopsel_kernel.sv | 174 +++++++++++++++++
 tb/tb_hopsel_kernel.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_hop_pkg.sv
// Shared constants, FSM states, butterfly table and channel mapping for the hop selection kernel.
package bt_hop_pkg;

    localparam int unsigned NUM_CH    = 79;
    localparam int unsigned HALF_CH   = 40;
    localparam int unsigned AFH_N_MIN = 20;
    localparam int unsigned AFH_N_MAX = 79;
    localparam int unsigned NUM_BFLY  = 14;

    typedef enum logic [2:0] {
        IDLE,
        PERM,
        MODB,
        CHK,
        MODA,
        SCAN,
        DONE
    } hop_state_t;

    // Hop control word captured at start_p.
    typedef struct packed {
        logic [4:0] x;
        logic       y1;
        logic [5:0] y2;
        logic [4:0] a;
        logic [3:0] b;
        logic [4:0] c;
        logic [8:0] d;
        logic [6:0] e;
        logic [6:0] f;
        logic [6:0] fp;
    } hop_word_t;

    // Butterfly i swaps Z bits BFLY_LO[i] and BFLY_HI[i].
    localparam int unsigned BFLY_LO [NUM_BFLY] = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
    localparam int unsigned BFLY_HI [NUM_BFLY] = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};

    // Even-then-odd index to RF channel: k < 40 -> 2k, else 2(k-40)+1.
    function automatic logic [6:0] ch_of_idx(input logic [6:0] k);
        if (k < 7'(HALF_CH))
            return 7'(k << 1);
        else
            return 7'(((k - 7'(HALF_CH)) << 1) | 7'd1);
    endfunction

endpackage

// File: rtl/hop_perm.sv
// Combinational 14-stage butterfly permutation of the 5-bit Z word, P13 applied first.
module hop_perm
    import bt_hop_pkg::BFLY_LO;
    import bt_hop_pkg::BFLY_HI;
    import bt_hop_pkg::NUM_BFLY;
(
    input  logic [4:0]  Z,
    input  logic [13:0] P,
    output logic [4:0]  PERM
);

    logic [4:0] v;
    logic [2:0] lo;
    logic [2:0] hi;
    logic       t;

    always_comb begin
        v  = Z;
        lo = 3'd0;
        hi = 3'd0;
        t  = 1'b0;
        for (int i = int'(NUM_BFLY) - 1; i >= 0; i--) begin
            lo = 3'(BFLY_LO[i]);
            hi = 3'(BFLY_HI[i]);
            if (P[i]) begin
                t     = v[lo];
                v[lo] = v[hi];
                v[hi] = t;
            end
        end
    end

    assign PERM = v;

endmodule

// File: rtl/hopsel_kernel.sv
// Hop selection kernel: permutation, mod-79 reduction and optional adaptive remap to one RF channel.
module hopsel_kernel
    import bt_hop_pkg::*;
(
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        start_p,
    input  logic        afh_en,
    input  logic [4:0]  X,
    input  logic        Y1,
    input  logic [5:0]  Y2,
    input  logic [4:0]  A,
    input  logic [3:0]  B,
    input  logic [4:0]  C,
    input  logic [8:0]  D,
    input  logic [6:0]  E,
    input  logic [6:0]  F,
    input  logic [6:0]  Fprime,
    input  logic [6:0]  regi_AFH_N,
    input  logic [78:0] afh_chmap,
    output logic        busy,
    output logic        done_p,
    output logic [6:0]  channel,
    output logic        afh_remapped,
    output logic        afh_err
);

    hop_state_t        state, state_nx;
    hop_word_t         hw_q;
    logic              afh_en_q;
    logic [NUM_CH-1:0] chmap_q;
    logic [6:0]        n_q;

    logic [4:0]  z_c;
    logic [13:0] p_c;
    logic [4:0]  perm_c;
    logic [4:0]  perm_q;
    logic [8:0]  s_q;
    logic [8:0]  sa_q;
    logic [6:0]  basic_q;
    logic [6:0]  pos_q;
    logic [6:0]  cnt_q;

    logic [6:0]  chk_ch_c;
    logic [6:0]  scan_ch_c;
    logic [6:0]  fin_ch_c;
    logic        fin_remap_c;
    logic        fin_err_c;
    logic        n_ok_c;
    logic        scan_used_c;

    assign z_c         = (hw_q.x + hw_q.a) ^ {1'b0, hw_q.b};
    assign p_c         = {hw_q.d, hw_q.c ^ {5{hw_q.y1}}};
    assign chk_ch_c    = ch_of_idx(s_q[6:0]);
    assign scan_ch_c   = ch_of_idx(pos_q);
    assign scan_used_c = chmap_q[scan_ch_c];
    assign n_ok_c      = (n_q >= 7'(AFH_N_MIN)) && (n_q <= 7'(AFH_N_MAX));

    hop_perm u_perm (
        .Z    (z_c),
        .P    (p_c),
        .PERM (perm_c)
    );

    // State register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and the result presented at done_p.
    always_comb begin
        state_nx    = state;
        fin_ch_c    = basic_q;
        fin_remap_c = 1'b0;
        fin_err_c   = 1'b0;
        case (state)
            IDLE: if (start_p) state_nx = PERM;
            PERM: state_nx = MODB;
            MODB: if (s_q < 9'(NUM_CH)) state_nx = CHK;
            CHK: begin
                fin_ch_c = chk_ch_c;
                if (!afh_en_q || chmap_q[chk_ch_c]) begin
                    state_nx = DONE;
                end else if (!n_ok_c) begin
                    fin_err_c = 1'b1;
                    state_nx  = DONE;
                end else begin
                    state_nx = MODA;
                end
            end
            MODA: if (sa_q < 9'(n_q)) state_nx = SCAN;
            SCAN: begin
                if (scan_used_c && (cnt_q == 7'(sa_q))) begin
                    fin_ch_c    = scan_ch_c;
                    fin_remap_c = 1'b1;
                    state_nx    = DONE;
                end else if (pos_q == 7'(NUM_CH - 1)) begin
                    fin_err_c = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Captured inputs and working registers.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            hw_q     <= '0;
            afh_en_q <= 1'b0;
            chmap_q  <= '0;
            n_q      <= '0;
            perm_q   <= '0;
            s_q      <= '0;
            sa_q     <= '0;
            basic_q  <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_p) begin
                        hw_q     <= '{x: X, y1: Y1, y2: Y2, a: A, b: B, c: C,
                                      d: D, e: E, f: F, fp: Fprime};
                        afh_en_q <= afh_en;
                        chmap_q  <= afh_chmap;
                        n_q      <= regi_AFH_N;
                    end
                end
                PERM: begin
                    perm_q <= perm_c;
                    s_q    <= 9'(perm_c) + 9'(hw_q.e) + 9'(hw_q.f) + 9'(hw_q.y2);
                end
                MODB: if (s_q >= 9'(NUM_CH)) s_q <= s_q - 9'(NUM_CH);
                CHK: begin
                    basic_q <= chk_ch_c;
                    sa_q    <= 9'(perm_q) + 9'(hw_q.e) + 9'(hw_q.fp) + 9'(hw_q.y2);
                end
                MODA: begin
                    pos_q <= '0;
                    cnt_q <= '0;
                    if (sa_q >= 9'(n_q)) sa_q <= sa_q - 9'(n_q);
                end
                SCAN: begin
                    pos_q <= pos_q + 7'd1;
                    if (scan_used_c) cnt_q <= cnt_q + 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; the result lands together with done_p.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            busy         <= 1'b0;
            done_p       <= 1'b0;
            channel      <= '0;
            afh_remapped <= 1'b0;
            afh_err      <= 1'b0;
        end else begin
            busy   <= (state_nx != IDLE);
            done_p <= (state_nx == DONE);
            if (state_nx == DONE) begin
                channel      <= fin_ch_c;
                afh_remapped <= fin_remap_c;
                afh_err      <= fin_err_c;
            end
        end
    end

endmodule

// File: tb/tb_hopsel_kernel.sv
// Directed and randomized checks of hopsel_kernel against an arithmetic reference model.
module tb_hopsel_kernel;

    logic        clk_6M = 1'b0;
    logic        rstz;
    logic        start_p;
    logic        afh_en;
    logic [4:0]  X;
    logic        Y1;
    logic [5:0]  Y2;
    logic [4:0]  A;
    logic [3:0]  B;
    logic [4:0]  C;
    logic [8:0]  D;
    logic [6:0]  E;
    logic [6:0]  F;
    logic [6:0]  Fprime;
    logic [6:0]  regi_AFH_N;
    logic [78:0] afh_chmap;
    logic        busy;
    logic        done_p;
    logic [6:0]  channel;
    logic        afh_remapped;
    logic        afh_err;

    int n_checks = 0;
    int n_fail   = 0;

    int lo_tab [14] = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
    int hi_tab [14] = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};

    always #83 clk_6M = ~clk_6M;

    hopsel_kernel dut (
        .clk_6M       (clk_6M),
        .rstz         (rstz),
        .start_p      (start_p),
        .afh_en       (afh_en),
        .X            (X),
        .Y1           (Y1),
        .Y2           (Y2),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .E            (E),
        .F            (F),
        .Fprime       (Fprime),
        .regi_AFH_N   (regi_AFH_N),
        .afh_chmap    (afh_chmap),
        .busy         (busy),
        .done_p       (done_p),
        .channel      (channel),
        .afh_remapped (afh_remapped),
        .afh_err      (afh_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int chan_of(input int k);
        return (k < 40) ? 2 * k : 2 * (k - 40) + 1;
    endfunction

    function automatic int model_perm(input int z, input int p);
        int b [5];
        int t;
        for (int i = 0; i < 5; i++) b[i] = (z >> i) & 1;
        for (int i = 13; i >= 0; i--) begin
            if (((p >> i) & 1) == 1) begin
                t = b[lo_tab[i]];
                b[lo_tab[i]] = b[hi_tab[i]];
                b[hi_tab[i]] = t;
            end
        end
        return b[0] + 2 * b[1] + 4 * b[2] + 8 * b[3] + 16 * b[4];
    endfunction

    // Expected channel/flags from the current input values; lat = -1 when the remap path runs.
    function automatic void model(output int ch, output int rm, output int er, output int lat);
        int z, p, perm, s, basic, n, sa;
        int used [$];
        z     = ((int'(X) + int'(A)) % 32) ^ int'(B);
        p     = int'(D) * 32 + (int'(C) ^ (Y1 ? 31 : 0));
        perm  = model_perm(z, p);
        s     = perm + int'(E) + int'(F) + int'(Y2);
        basic = chan_of(s % 79);
        lat   = 4 + s / 79;
        ch = basic; rm = 0; er = 0;
        n = int'(regi_AFH_N);
        if (!afh_en || afh_chmap[basic]) return;
        if (n < 20 || n > 79) begin
            er = 1;
            return;
        end
        lat = -1;
        sa = (perm + int'(E) + int'(Fprime) + int'(Y2)) % n;
        for (int k = 0; k < 79; k++) if (afh_chmap[chan_of(k)]) used.push_back(chan_of(k));
        if (sa < used.size()) begin
            ch = used[sa];
            rm = 1;
        end else begin
            er = 1;
        end
    endfunction

    task automatic zero_inputs();
        afh_en = 0; X = 0; Y1 = 0; Y2 = 0; A = 0; B = 0; C = 0; D = 0;
        E = 0; F = 0; Fprime = 0; regi_AFH_N = 7'd79; afh_chmap = '1;
    endtask

    // One hop: pulse start_p, wait (bounded) for done_p, compare with the model.
    task automatic do_hop(input string tag, input bit dbl_start);
        int ch, rm, er, lat, cyc, extra;
        model(ch, rm, er, lat);
        @(negedge clk_6M);
        start_p = 1;
        @(negedge clk_6M);
        start_p = 0;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy), 1);
        while (!done_p && cyc < 600) begin
            @(negedge clk_6M);
            cyc++;
            if (dbl_start && cyc == 2) start_p = 1;
            if (dbl_start && cyc == 3) start_p = 0;
        end
        check({tag, "_done"}, 32'(done_p), 1);
        check({tag, "_ch"}, 32'(channel), 32'(ch));
        check({tag, "_remap"}, 32'(afh_remapped), 32'(rm));
        check({tag, "_err"}, 32'(afh_err), 32'(er));
        if (lat >= 0) check({tag, "_lat"}, 32'(cyc), 32'(lat));
        @(negedge clk_6M);
        check({tag, "_pulse"}, 32'(done_p), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        if (dbl_start) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk_6M);
                if (done_p) extra++;
            end
            check({tag, "_extra_done"}, 32'(extra), 0);
        end
    endtask

    initial begin
        int ndone;
        logic [95:0] r;
        rstz = 0;
        start_p = 0;
        zero_inputs();
        repeat (3) @(negedge clk_6M);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done_p), 0);
        check("rst_ch", 32'(channel), 0);
        check("rst_remap", 32'(afh_remapped), 0);
        check("rst_err", 32'(afh_err), 0);
        rstz = 1;
        @(negedge clk_6M);

        // All zero: channel 0 after the minimum four cycles.
        do_hop("all_zero", 0);
        check("all_zero_ch_const", 32'(channel), 0);

        // S = 317, four mod-79 subtractions, channel 2.
        X = 31; E = 127; F = 127; Y2 = 32;
        do_hop("s317", 0);
        check("s317_ch_const", 32'(channel), 2);

        zero_inputs(); E = 40;
        do_hop("k40", 0);
        check("k40_ch_const", 32'(channel), 1);

        zero_inputs(); E = 5;
        do_hop("k5", 0);
        check("k5_ch_const", 32'(channel), 10);

        // Basic channel 10 unused, remap to 12.
        afh_en = 1; afh_chmap = '1; afh_chmap[10] = 1'b0; regi_AFH_N = 78;
        do_hop("remap", 0);
        check("remap_ch_const", 32'(channel), 12);
        check("remap_flag_const", 32'(afh_remapped), 1);

        // N out of range with a second start while busy.
        regi_AFH_N = 10;
        do_hop("bad_n", 1);
        check("bad_n_ch_const", 32'(channel), 10);
        check("bad_n_err_const", 32'(afh_err), 1);

        // N above range and an empty map.
        regi_AFH_N = 100;
        do_hop("n_hi", 0);
        regi_AFH_N = 40; afh_chmap = '0;
        do_hop("empty_map", 0);

        // Reset in the middle of SCAN.
        afh_chmap = '1; afh_chmap[10] = 1'b0; regi_AFH_N = 20; Fprime = 60;
        @(negedge clk_6M);
        start_p = 1;
        @(negedge clk_6M);
        start_p = 0;
        repeat (9) @(negedge clk_6M);
        check("abort_busy_before", 32'(busy), 1);
        rstz = 0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_ch", 32'(channel), 0);
        check("abort_done", 32'(done_p), 0);
        @(negedge clk_6M);
        rstz = 1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_6M);
            if (done_p) ndone++;
        end
        check("abort_no_done", 32'(ndone), 0);
        do_hop("after_abort", 0);
        check("after_abort_ch_const", 32'(channel), 12);

        // Randomized hops.
        for (int i = 0; i < 60; i++) begin
            X = 5'($urandom); Y1 = 1'($urandom); Y2 = 6'($urandom);
            A = 5'($urandom); B = 4'($urandom); C = 5'($urandom);
            D = 9'($urandom); E = 7'($urandom); F = 7'($urandom);
            Fprime = 7'($urandom);
            afh_en = ($urandom_range(0, 3) != 0);
            r = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r = r & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
            afh_chmap = r[78:0];
            if ($urandom_range(0, 7) == 0) regi_AFH_N = 7'($urandom);
            else regi_AFH_N = 7'($urandom_range(20, 79));
            do_hop("rand", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
